// File: rtl/l1_ctrl_arbiter.sv
// rtl/l1_ctrl_arbiter.sv - lock arbiter granting the datapath FSM to CPU FSM A or snoop FSM B
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous active-high reset
//   acq_a/acq_b  lock requests from FSM A (CPU side) / FSM B (snoop)
//   rel_a/rel_b  single-cycle release pulses from the current owner
//   ack_a/ack_b  single-cycle grant pulses
//   busy         lock held or being granted
//   owner        current or pending owner (0 = A, 1 = B), valid while busy
//   err_timeout  sticky watchdog flag, lock held for TIMEOUT cycles
module l1_ctrl_arbiter #(
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic acq_a,
  input  logic acq_b,
  input  logic rel_a,
  input  logic rel_b,
  output logic ack_a,
  output logic ack_b,
  output logic busy,
  output logic owner,
  output logic err_timeout
);

  localparam int HW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [3:0]    STARVE_LIM = 4'(STARVE_MAX);
  localparam logic [HW-1:0] HOLD_LIM   = HW'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT  = 2'd1,
    BUSY   = 2'd2,
    CANCEL = 2'd3
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [3:0]    starve_cnt;
  logic [HW-1:0] hold_cnt;
  logic          owner_q;
  logic          ack_a_q;
  logic          ack_b_q;
  logic          err_q;

  logic          b_wins;
  logic          owner_acq;
  logic          owner_rel;

  always_comb begin
    // Snoop side wins ties unless the CPU side has been passed over too often.
    b_wins    = acq_b && !(acq_a && (starve_cnt == STARVE_LIM));
    owner_acq = owner_q ? acq_b : acq_a;
    owner_rel = owner_q ? rel_b : rel_a;

    state_nxt = state;
    case (state)
      IDLE:    if (acq_a || acq_b) state_nxt = GRANT;
      GRANT:   state_nxt = owner_acq ? BUSY : CANCEL;
      BUSY:    if (owner_rel) state_nxt = IDLE;
      CANCEL:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q    <= 1'b0;
      starve_cnt <= 4'd0;
      hold_cnt   <= '0;
      err_q      <= 1'b0;
      ack_a_q    <= 1'b0;
      ack_b_q    <= 1'b0;
    end else begin
      // The ack is registered on the GRANT->BUSY edge, so it appears in the
      // first BUSY cycle, two cycles after the request hit an idle arbiter.
      ack_a_q <= (state == GRANT) && owner_acq && !owner_q;
      ack_b_q <= (state == GRANT) && owner_acq &&  owner_q;

      if ((state == IDLE) && (acq_a || acq_b)) begin
        owner_q <= b_wins;
        if (b_wins && acq_a) begin
          if (starve_cnt != STARVE_LIM) starve_cnt <= starve_cnt + 4'd1;
        end else begin
          starve_cnt <= 4'd0;
        end
      end

      // Clearing throughout GRANT leaves the counter at zero on BUSY entry.
      if (state == GRANT) begin
        hold_cnt <= '0;
      end else if ((state == BUSY) && (hold_cnt != HOLD_LIM)) begin
        hold_cnt <= hold_cnt + HW'(1);
      end

      // Flag on the edge where the hold count reaches TIMEOUT; no forced release.
      if ((TIMEOUT != 0) && (state == BUSY) && (hold_cnt != HOLD_LIM) &&
          ((hold_cnt + HW'(1)) == HOLD_LIM)) begin
        err_q <= 1'b1;
      end
    end
  end

  assign ack_a       = ack_a_q;
  assign ack_b       = ack_b_q;
  assign busy        = (state == GRANT) || (state == BUSY);
  assign owner       = owner_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_l1_ctrl_arbiter.sv
// tb/tb_l1_ctrl_arbiter.sv - self-checking bench for l1_ctrl_arbiter
module tb_l1_ctrl_arbiter;

  localparam int SM = 4;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic reset, acq_a, acq_b, rel_a, rel_b;
  logic ack_a, ack_b, busy, owner, err_timeout;

  int errors = 0;
  int checks = 0;

  l1_ctrl_arbiter #(.STARVE_MAX(SM), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .acq_a(acq_a), .acq_b(acq_b), .rel_a(rel_a), .rel_b(rel_b),
    .ack_a(ack_a), .ack_b(ack_b), .busy(busy), .owner(owner),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: lock phase (free / granting / held / cooling down),
  // winner choice from the tie-break rule, starvation as a clamped integer,
  // and hold time as an integer count of completed BUSY cycles.
  int m_phase = 0;   // 0 free, 1 granting, 2 held, 3 cooling down
  int m_own = 0;
  int m_starve = 0;
  int m_held = 0;
  int m_err = 0;
  int e_ack_a = 0, e_ack_b = 0;
  bit m_valid = 1'b0;

  always @(posedge clk) begin
    int give;
    give = 0;
    if (reset) begin
      m_phase = 0; m_own = 0; m_starve = 0; m_held = 0; m_err = 0;
      m_valid = 1'b1;
    end else begin
      case (m_phase)
        0: if (acq_a || acq_b) begin
             if (acq_b && !(acq_a && m_starve == SM)) begin
               m_own = 1;
               m_starve = acq_a ? ((m_starve + 1 > SM) ? SM : m_starve + 1) : 0;
             end else begin
               m_own = 0;
               m_starve = 0;
             end
             m_phase = 1;
           end
        1: if ((m_own == 1) ? acq_b : acq_a) begin
             m_phase = 2; m_held = 0; give = 1;
           end else begin
             m_phase = 3;
           end
        2: begin
             m_held++;
             if (TO != 0 && m_held >= TO) m_err = 1;
             if ((m_own == 1) ? rel_b : rel_a) m_phase = 0;
           end
        default: m_phase = 0;
      endcase
    end
    e_ack_a = give & (m_own == 0);
    e_ack_b = give & (m_own == 1);
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("ack_a", ack_a, e_ack_a);
      chk("ack_b", ack_b, e_ack_b);
      chk("busy", busy, (m_phase == 1 || m_phase == 2) ? 1 : 0);
      chk("err_timeout", err_timeout, m_err);
      if (m_phase == 1 || m_phase == 2) chk("owner", owner, m_own);
      chk("ack_exclusive", ack_a & ack_b, 0);
    end
  end

  task automatic step(input logic a, input logic b, input logic ra,
                      input logic rb, input logic rs);
    acq_a = a; acq_b = b; rel_a = ra; rel_b = rb; reset = rs;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
  endtask

  initial begin
    int order[6];
    int ng;
    int cd;
    int who;
    bit rl;

    acq_a = 0; acq_b = 0; rel_a = 0; rel_b = 0; reset = 1;
    do_reset();
    chk("rst_busy", busy, 0);
    chk("rst_ack", ack_a | ack_b, 0);
    chk("rst_owner", owner, 0);
    chk("rst_err", err_timeout, 0);

    // Single A request: busy/owner at +1, ack at +2 only, release frees at +1.
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    chk("s1_busy_c1", busy, 1);
    chk("s1_owner_c1", owner, 0);
    chk("s1_ack_c1", ack_a, 0);
    step(1, 0, 0, 0, 0);
    chk("s1_ack_c2", ack_a, 1);
    step(0, 0, 0, 0, 0);
    chk("s1_ack_c3", ack_a, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("s1_busy_c5", busy, 1);
    step(0, 0, 1, 0, 0);
    chk("s1_busy_c6", busy, 0);

    // Both requesting continuously: starvation relief every fifth grant.
    do_reset();
    ng = 0; cd = -1; who = 0;
    for (int it = 0; it < 120 && ng < 6; it++) begin
      if (ack_a || ack_b) begin
        order[ng] = ack_b ? 1 : 0;
        ng++;
        who = ack_b ? 1 : 0;
        cd = 2;
      end
      rl = (cd == 0);
      step(1, 1, rl && (who == 0), rl && (who == 1), 0);
      if (cd >= 0) cd--;
    end
    chk("s2_grants", ng, 6);
    chk("s2_g0", order[0], 1);
    chk("s2_g1", order[1], 1);
    chk("s2_g2", order[2], 1);
    chk("s2_g3", order[3], 1);
    chk("s2_g4", order[4], 0);
    chk("s2_g5", order[5], 1);

    // Withdrawn B request is cancelled without an ack; A is served afterwards.
    do_reset();
    step(0, 1, 0, 0, 0);
    chk("s3_busy_c1", busy, 1);
    chk("s3_owner_c1", owner, 1);
    step(0, 0, 0, 0, 0);
    chk("s3_busy_c2", busy, 0);
    chk("s3_ackb_c2", ack_b, 0);
    step(0, 0, 0, 0, 0);
    chk("s3_busy_c3", busy, 0);
    step(1, 0, 0, 0, 0);
    chk("s3_owner_c4", owner, 0);
    step(1, 0, 0, 0, 0);
    chk("s3_acka_c5", ack_a, 1);
    step(0, 0, 1, 0, 0);

    // Foreign release ignored; release plus new request gives ack three cycles later.
    do_reset();
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    chk("s4_acka", ack_a, 1);
    step(0, 0, 0, 1, 0);
    chk("s4_busy_relb", busy, 1);
    chk("s4_owner_relb", owner, 0);
    step(0, 1, 1, 0, 0);
    chk("s4_busy_free", busy, 0);
    step(0, 1, 0, 0, 0);
    chk("s4_owner_b", owner, 1);
    chk("s4_ackb_early", ack_b, 0);
    step(0, 1, 0, 0, 0);
    chk("s4_ackb_t3", ack_b, 1);
    step(0, 0, 0, 1, 0);

    // Watchdog: B never releases.
    do_reset();
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    chk("s5_ackb", ack_b, 1);
    for (int i = 0; i < 7; i++) step(0, 0, 0, 0, 0);
    chk("s5_err_early", err_timeout, 0);
    step(0, 0, 0, 0, 0);
    chk("s5_err_set", err_timeout, 1);
    chk("s5_busy_held", busy, 1);
    step(0, 0, 0, 0, 0);
    chk("s5_err_sticky", err_timeout, 1);
    step(0, 0, 0, 0, 1);
    chk("s5_rst_err", err_timeout, 0);
    chk("s5_rst_busy", busy, 0);
    chk("s5_rst_owner", owner, 0);
    chk("s5_rst_ack", ack_a | ack_b, 0);

    // Reset during GRANT suppresses the ack; a fresh request is granted normally.
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    chk("s6_busy_grant", busy, 1);
    step(1, 0, 0, 0, 1);
    chk("s6_ack_killed", ack_a, 0);
    chk("s6_busy_killed", busy, 0);
    step(1, 0, 0, 0, 0);
    chk("s6_busy_regrant", busy, 1);
    step(1, 0, 0, 0, 0);
    chk("s6_ack_regrant", ack_a, 1);
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/l1_ctrl_arbiter.md
L1_CTRL_ARBITER -- requirements
Module: l1_ctrl_arbiter

Interface
REQ-001 Parameter STARVE_MAX, default 4, meaning: number of consecutive snoop-side grants allowed while the CPU side waits; range 1..15.
REQ-002 Parameter TIMEOUT, default 1024, meaning: number of cycles the lock may be held before the watchdog flags an error; 0 disables the watchdog.
REQ-003 clk  input  1  clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 acq_a  input  1  CPU-side FSM A requests the datapath (FSM C) lock.
REQ-006 acq_b  input  1  snoop FSM B requests the datapath lock.
REQ-007 rel_a  input  1  FSM A releases the lock (single-cycle pulse).
REQ-008 rel_b  input  1  FSM B releases the lock (single-cycle pulse).
REQ-009 ack_a  output  1  single-cycle grant pulse to FSM A.
REQ-010 ack_b  output  1  single-cycle grant pulse to FSM B.
REQ-011 busy  output  1  lock is held or is being granted (state GRANT or BUSY).
REQ-012 owner  output  1  current or pending owner: 0 = A, 1 = B; valid while busy=1.
REQ-013 err_timeout  output  1  sticky watchdog error flag.

Function
REQ-014 The arbiter SHALL have four states: IDLE, GRANT, BUSY and CANCEL. All outputs SHALL be decoded from registered state only.
REQ-015 IDLE, no acq asserted: the arbiter SHALL stay in IDLE.
REQ-016 IDLE, any acq asserted: the arbiter SHALL select a winner per REQ-021..REQ-023, register it in owner, and go to GRANT.
REQ-017 GRANT, owner's acq still high: the arbiter SHALL assert ack_owner for exactly one cycle and go to BUSY.
REQ-018 GRANT, owner's acq low (the request was withdrawn): the arbiter SHALL issue no ack and go to CANCEL.
REQ-019 CANCEL: the arbiter SHALL spend one cycle with busy=0, then go to IDLE.
REQ-020 BUSY: the arbiter SHALL stay in BUSY until rel_owner=1, then go to IDLE.
  - A rel pulse from the non-owner SHALL be ignored.
  - acq inputs SHALL be ignored while in BUSY.
REQ-021 Arbitration, single requester: that requester SHALL win.
REQ-022 Arbitration, both requesting: B SHALL win (snoop priority), unless starve_cnt == STARVE_MAX, in which case A SHALL win.
REQ-023 starve_cnt SHALL be updated as follows:
  - Width 4 bits, saturating at STARVE_MAX.
  - +1 on every B win while acq_a=1.
  - Cleared on an A win.
  - Cleared on a B win while acq_a=0.
  - Updated only in the IDLE-to-GRANT transition.
REQ-024 Latency:
  - acq arriving at an idle arbiter in cycle t SHALL produce ack in cycle t+2.
  - A rel in cycle t SHALL allow the next ack no earlier than cycle t+3.
REQ-025 rel_owner and a new acq in the same cycle: the release SHALL take effect first, and the new request SHALL be arbitrated in IDLE in the next cycle.
REQ-026 ack_a and ack_b SHALL never be asserted in the same cycle. At most one ack SHALL be asserted per grant.
REQ-027 Watchdog:
  - hold_cnt has width clog2(TIMEOUT+1). It SHALL clear on entry to BUSY and increment each cycle in BUSY, saturating.
  - When TIMEOUT != 0 and hold_cnt reaches TIMEOUT, err_timeout SHALL set and remain set until reset.
  - The watchdog SHALL NOT force a release.
REQ-028 A rel pulse arriving in IDLE, GRANT or CANCEL SHALL be ignored.

Reset
REQ-029 While reset=1, the block SHALL drive: state=IDLE, owner=0, starve_cnt=0, hold_cnt=0, err_timeout=0, ack_a=0, ack_b=0, busy=0.
REQ-030 Reset asserted mid-grant or in BUSY SHALL return the block to IDLE in the next cycle with no ack issued. The lock SHALL be treated as free.

Verification
REQ-031 acq_a=1 alone at cycle 0 -> busy=1 and owner=0 at cycle 1, ack_a=1 at cycle 2 only; rel_a at cycle 5 -> busy=0 at cycle 6.
REQ-032 acq_a=acq_b=1 held, each grant released 2 cycles after its ack, STARVE_MAX=4 -> grant order B,B,B,B,A,B,...; ack_a and ack_b never asserted together.
REQ-033 acq_b pulsed 1 cycle in IDLE, then dropped -> GRANT then CANCEL, no ack_b, busy=0 two cycles later, arbiter then accepts acq_a.
REQ-034 A owns the lock, rel_b pulsed -> remains BUSY with owner=0; rel_a plus acq_b in the same cycle -> ack_b exactly 3 cycles after rel_a.
REQ-035 TIMEOUT=8, B acquires and never releases -> err_timeout=1 after 8 cycles in BUSY, busy stays 1; reset -> all outputs 0.
REQ-036 Reset asserted in the GRANT cycle -> no ack pulse, IDLE on the next cycle, a new acq then granted normally.
